spike_event_encoder: RTL and testbench

//  Downstream consumer of the LIF neuron's spike output. Stamps every spike with a free-running

---
 rtl/snn_pkg.sv | 5 +
 rtl/spike_evt_fifo.sv | 38 +++
 rtl/spike_event_encoder.sv | 58 +++++
 tb/tb_spike_event_encoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared timestamp width and type for the spiking pipeline
package snn_pkg;
  localparam int SNN_TS_W = 8;
  typedef logic [SNN_TS_W-1:0] snn_ts_t;
endpackage

// File: rtl/spike_evt_fifo.sv
// spike_evt_fifo: synchronous show-ahead FIFO with push/pop/full/empty/level
module spike_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/spike_event_encoder.sv
// spike_event_encoder: timestamps spikes into a show-ahead FIFO; SPIKE_DROP_CNT_EN adds a saturating drop counter
module spike_event_encoder
  import snn_pkg::*;
#(
  parameter int TS_W  = SNN_TS_W,
  parameter int DEPTH = 4
`ifdef SPIKE_DROP_CNT_EN
  , parameter int DROP_W = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   spike_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W-1:0]        evt_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_overflow
`ifdef SPIKE_DROP_CNT_EN
  , output logic [DROP_W-1:0]    drop_cnt
`endif
);
  logic [TS_W-1:0] ts;
  logic full, empty, spk, drop, push;
  assign spk       = en & spike_in;
  assign drop      = spk & full & ~evt_ready;
  assign push      = spk & ~drop;
  assign evt_valid = ~empty;
  always_ff @(posedge clk) begin
    if (!rst_n) ts <= '0;
    else if (en) ts <= ts + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end
`ifdef SPIKE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else if (clr_overflow) drop_cnt <= DROP_W'(drop);
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end
`endif
  spike_evt_fifo #(.WIDTH(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (ts),
    .pop   (evt_ready),
    .rdata (evt_ts),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_spike_event_encoder.sv
// tb_spike_event_encoder: directed scenarios plus random traffic against a queue-based model
module tb_spike_event_encoder;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, spike_in = 1'b0, evt_ready = 1'b0, clr_overflow = 1'b0;
  logic evt_valid, overflow;
  logic [7:0] evt_ts;
  logic [2:0] level;
`ifdef SPIKE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  int ts = 0, dc = 0;
  logic ovf = 1'b0;

  spike_event_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .spike_in     (spike_in),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_ts       (evt_ts),
    .level        (level),
    .overflow     (overflow),
`ifdef SPIKE_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    logic pop, spk, drop;
    if (!rst_n) begin
      q.delete();
      ts = 0; ovf = 1'b0; dc = 0;
    end else begin
      pop  = q.size() > 0 && evt_ready;
      spk  = en && spike_in;
      drop = spk && q.size() == DEPTH && !pop;
      if (pop) void'(q.pop_front());
      if (spk && !drop) q.push_back(8'(ts));
      if (drop) ovf = 1'b1;
      else if (clr_overflow) ovf = 1'b0;
      if (clr_overflow) dc = drop ? 1 : 0;
      else if (drop && dc < 255) dc++;
      if (en) ts = (ts + 1) % 256;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic rd, input logic c);
    rst_n = r; en = e; spike_in = s; evt_ready = rd; clr_overflow = c;
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("valid", evt_valid, q.size() != 0);
    chk("level", level, q.size());
    if (q.size() != 0) chk("head_ts", evt_ts, q[0]);
    chk("overflow", overflow, ovf);
`ifdef SPIKE_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, dc);
`endif
  endtask

  initial begin
    // reset held with activity on the inputs
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ts", evt_ts, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_first_stamp", evt_ts, 0);
    // single event at ts=5, held under backpressure
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("single_valid", evt_valid, 1);
    chk("single_ts", evt_ts, 5);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    chk("single_hold", evt_ts, 5);
    step(1, 1, 0, 1, 0);
    chk("single_popped", evt_valid, 0);
    // burst past capacity
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
    chk("burst_level", level, 4);
    chk("burst_ovf", overflow, 1);
`ifdef SPIKE_DROP_CNT_EN
    chk("burst_drops", drop_cnt, 2);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("burst_order", evt_ts, i);
      step(1, 1, 0, 1, 0);
    end
    step(1, 1, 0, 0, 1);
    chk("clr_ovf", overflow, 0);
`ifdef SPIKE_DROP_CNT_EN
    chk("clr_drops", drop_cnt, 0);
`endif
    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 1, 0);
      chk("pp_level", level, 4);
      chk("pp_ovf", overflow, 0);
    end
    // drop and clear in the same cycle: set wins
    step(1, 1, 1, 0, 1);
    chk("set_wins", overflow, 1);
`ifdef SPIKE_DROP_CNT_EN
    chk("set_wins_cnt", drop_cnt, 1);
`endif
    // timestamp wrap, then en gating
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 254; i++) step(1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    chk("gate_level", level, 3);
    chk("wrap_a", evt_ts, 254);
    step(1, 0, 0, 1, 0);
    chk("wrap_b", evt_ts, 255);
    step(1, 0, 0, 1, 0);
    chk("wrap_c", evt_ts, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    chk("frozen_ts", evt_ts, 1);
    // mid-operation reset
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 0);
    chk("mid_level", level, 3);
    step(0, 1, 1, 0, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_level", level, 0);
    step(1, 1, 1, 0, 0);
    chk("mid_rst_ts", evt_ts, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
